// File: rtl/dft_tap_core_pkg.sv
// Shared TAP state encoding, opcodes and BIST helpers
// for the dft_tap_core test access port.
package dft_tap_core_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_t;

  typedef struct packed {
    logic cap_ir;
    logic shift_ir;
    logic upd_ir;
    logic cap_dr;
    logic shift_dr;
    logic upd_dr;
    logic in_tlr;
    logic in_idle;
    logic tlr_next;
  } tap_strobe_t;

  localparam int OP_EXTEST  = 0;
  localparam int OP_IDCODE  = 1;
  localparam int OP_SAMPLE  = 2;
  localparam int OP_RUNBIST = 3;

  localparam int LFSR_MAX_W = 32;

  // Right-shifting Galois step; callers keep upper bits zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] poly
  );
    lfsr_step = (s >> 1) ^ (s[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/dft_tap_core_fsm.sv
// 16-state TAP controller: state register, next-state
// logic and decoded capture/shift/update strobes.
module dft_tap_core_fsm
  import dft_tap_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tms_i,
  output tap_strobe_t strb_o
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TAP_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:      state_d = tms_i ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   state_d = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:    state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR:   state_d = tms_i ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_d = tms_i ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   state_d = tms_i ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR:   state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   state_d = tms_i ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:    state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR:   state_d = tms_i ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_d = tms_i ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   state_d = tms_i ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR:   state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
    endcase
  end

  always_comb begin
    strb_o          = '0;
    strb_o.cap_ir   = (state_q == TAP_CAP_IR);
    strb_o.shift_ir = (state_q == TAP_SH_IR);
    strb_o.upd_ir   = (state_q == TAP_UPD_IR);
    strb_o.cap_dr   = (state_q == TAP_CAP_DR);
    strb_o.shift_dr = (state_q == TAP_SH_DR);
    strb_o.upd_dr   = (state_q == TAP_UPD_DR);
    strb_o.in_tlr   = (state_q == TAP_TLR);
    strb_o.in_idle  = (state_q == TAP_RTI);
    strb_o.tlr_next = (state_d == TAP_TLR);
  end

endmodule

// File: rtl/dft_tap_core.sv
// Test access core: TAP controller, instruction register,
// bypass/IDCODE/boundary/BIST-signature data registers.
module dft_tap_core
  import dft_tap_core_pkg::*;
#(
  parameter int                IR_W      = 4,
  parameter int                BSR_LEN   = 39,
  parameter logic [31:0]       IDCODE    = 32'h1876_5001,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hB400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tms,
  input  logic               tdi,
  output logic               tdo,
  output logic               tdo_en,
  input  logic [BSR_LEN-1:0] bsr_cap,
  output logic [BSR_LEN-1:0] bsr_upd,
  output logic               extest_mode,
  output logic [LFSR_W-1:0]  bist_pattern,
  output logic               bist_busy,
  output logic [IR_W-1:0]    ir_q
);

  localparam logic [IR_W-1:0] IR_EXTEST  = IR_W'(OP_EXTEST);
  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(OP_IDCODE);
  localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(OP_SAMPLE);
  localparam logic [IR_W-1:0] IR_RUNBIST = IR_W'(OP_RUNBIST);
  localparam logic [IR_W-1:0] IR_CAPT    = IR_W'(1);
  localparam logic [LFSR_W-1:0] SEED     = LFSR_W'(1);

  tap_strobe_t st;

  dft_tap_core_fsm u_fsm (
    .clk    (clk),
    .reset  (reset),
    .tms_i  (tms),
    .strb_o (st)
  );

  logic [IR_W-1:0]    ir_d;
  logic [IR_W-1:0]    ir_sr_q, ir_sr_d;
  logic               byp_q, byp_d;
  logic [31:0]        id_q, id_d;
  logic [BSR_LEN-1:0] bsr_q, bsr_d;
  logic [BSR_LEN-1:0] upd_q, upd_d;
  logic [LFSR_W-1:0]  sig_q, sig_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]  misr_q, misr_d;
  logic [LFSR_W-1:0]  cap_lo;

  logic sel_bsr, sel_id, sel_sig;
  logic dr_lsb;

  if (BSR_LEN >= LFSR_W) begin : g_cap_trunc
    assign cap_lo = bsr_cap[LFSR_W-1:0];
  end else begin : g_cap_ext
    assign cap_lo = {{(LFSR_W-BSR_LEN){1'b0}}, bsr_cap};
  end

  assign sel_bsr = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
  assign sel_id  = (ir_q == IR_IDCODE);
  assign sel_sig = (ir_q == IR_RUNBIST);

  assign bist_busy    = st.in_idle && sel_sig;
  assign extest_mode  = (ir_q == IR_EXTEST);
  assign bsr_upd      = upd_q;
  assign bist_pattern = lfsr_q;
  assign tdo_en       = st.shift_ir || st.shift_dr;

  always_comb begin
    dr_lsb = byp_q;
    unique case (1'b1)
      sel_bsr: dr_lsb = bsr_q[0];
      sel_id:  dr_lsb = id_q[0];
      sel_sig: dr_lsb = sig_q[0];
      default: dr_lsb = byp_q;
    endcase
  end

  always_comb begin
    tdo = 1'b0;
    if (st.shift_ir) begin
      tdo = ir_sr_q[0];
    end else if (st.shift_dr) begin
      tdo = dr_lsb;
    end
  end

  always_comb begin
    ir_d    = ir_q;
    ir_sr_d = ir_sr_q;
    byp_d   = byp_q;
    id_d    = id_q;
    bsr_d   = bsr_q;
    upd_d   = upd_q;
    sig_d   = sig_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;

    if (st.cap_ir) begin
      ir_sr_d = IR_CAPT;
    end else if (st.shift_ir) begin
      ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
    end

    if (st.upd_ir) begin
      ir_d = ir_sr_q;
    end
    if (st.tlr_next || st.in_tlr) begin
      ir_d = IR_IDCODE;
    end

    if (st.cap_dr) begin
      unique case (1'b1)
        sel_bsr: bsr_d = bsr_cap;
        sel_id:  id_d  = IDCODE;
        sel_sig: sig_d = misr_q;
        default: byp_d = 1'b0;
      endcase
    end else if (st.shift_dr) begin
      unique case (1'b1)
        sel_bsr: bsr_d = {tdi, bsr_q[BSR_LEN-1:1]};
        sel_id:  id_d  = {tdi, id_q[31:1]};
        sel_sig: sig_d = {tdi, sig_q[LFSR_W-1:1]};
        default: byp_d = tdi;
      endcase
    end

    if (st.upd_dr && sel_bsr) begin
      upd_d = bsr_q;
    end

    if (bist_busy) begin
      lfsr_d = LFSR_W'(lfsr_step(32'(lfsr_q), 32'(LFSR_POLY)));
      misr_d = LFSR_W'(lfsr_step(32'(misr_q), 32'(LFSR_POLY)))
             ^ cap_lo;
    end

    // Switching away from RUNBIST restarts the BIST run from seed.
    if (st.upd_ir && (ir_sr_q != IR_RUNBIST)) begin
      lfsr_d = SEED;
      misr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= IR_IDCODE;
      ir_sr_q <= IR_CAPT;
      byp_q   <= 1'b0;
      id_q    <= '0;
      bsr_q   <= '0;
      upd_q   <= '0;
      sig_q   <= '0;
      lfsr_q  <= SEED;
      misr_q  <= '0;
    end else begin
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      byp_q   <= byp_d;
      id_q    <= id_d;
      bsr_q   <= bsr_d;
      upd_q   <= upd_d;
      sig_q   <= sig_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
    end
  end

endmodule

// File: tb/tb_dft_tap_core.sv
// Bench for dft_tap_core: vector table, directed TAP walks
// and a random op mix against a scan-level reference model.
module tb_dft_tap_core;

  localparam logic [31:0] IDC  = 32'h1876_5001;
  localparam logic [15:0] POLY = 16'hB400;

  logic        clk = 1'b0;
  logic        reset, tms, tdi;
  logic        tdo, tdo_en, extest_mode, bist_busy;
  logic [38:0] bsr_cap, bsr_upd;
  logic [15:0] bist_pattern;
  logic [3:0]  ir_q;

  always #5 clk = ~clk;

  dft_tap_core dut (
    .clk          (clk),
    .reset        (reset),
    .tms          (tms),
    .tdi          (tdi),
    .tdo          (tdo),
    .tdo_en       (tdo_en),
    .bsr_cap      (bsr_cap),
    .bsr_upd      (bsr_upd),
    .extest_mode  (extest_mode),
    .bist_pattern (bist_pattern),
    .bist_busy    (bist_busy),
    .ir_q         (ir_q)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0]  m_ir;
  logic [15:0] m_lfsr, m_misr;
  logic [38:0] m_upd;

  typedef struct {
    logic [3:0]  op;
    int          len;
    logic [63:0] din;
    logic [38:0] cap;
    logic [63:0] dout;
    logic [38:0] upd;
    logic        ext;
    logic        chk_upd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic t_ms, input logic t_di,
                      output logic o_tdo, output logic o_en,
                      output logic o_busy);
    tms = t_ms;
    tdi = t_di;
    @(negedge clk);
    o_tdo  = tdo;
    o_en   = tdo_en;
    o_busy = bist_busy;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic t_ms);
    logic a, b, c;
    tick(t_ms, 1'b0, a, b, c);
  endtask

  task automatic hw_reset();
    reset = 1'b1;
    tms   = 1'b1;
    tdi   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic scan_ir(input logic [3:0] op,
                         output logic [3:0] so,
                         output logic en_ok);
    logic o, e, b;
    en_ok = 1'b1;
    so = '0;
    go(1); go(1); go(0); go(0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, op[i], o, e, b);
      so[i] = o;
      en_ok &= e;
    end
    go(1); go(0);
  endtask

  task automatic scan_dr(input int len, input logic [63:0] din,
                         output logic [63:0] dout,
                         output logic en_ok);
    logic o, e, b;
    en_ok = 1'b1;
    dout = '0;
    go(1); go(0); go(0);
    for (int i = 0; i < len; i++) begin
      tick(i == len - 1, din[i], o, e, b);
      dout[i] = o;
      en_ok &= e;
    end
    go(1); go(0);
  endtask

  function automatic logic [15:0] gstep(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 16'h0);
  endfunction

  // One clock spent in Run-Test/Idle under the model's IR.
  task automatic m_bist_tick();
    if (m_ir == 4'd3) begin
      m_lfsr = gstep(m_lfsr);
      m_misr = gstep(m_misr) ^ bsr_cap[15:0];
    end
  endtask

  task automatic m_init();
    m_ir   = 4'd1;
    m_lfsr = 16'd1;
    m_misr = 16'd0;
    m_upd  = '0;
  endtask

  task automatic m_scan_ir(input logic [3:0] op);
    logic [3:0] so;
    logic en;
    m_bist_tick();
    scan_ir(op, so, en);
    m_ir = op;
    if (op != 4'd3) begin
      m_lfsr = 16'd1;
      m_misr = 16'd0;
    end
    check("m_ir_cap", so, 4'b0001);
    check("m_ir_en", en, 1'b1);
    check("m_ir_q", ir_q, op);
    check("m_extest", extest_mode, op == 4'd0);
    check("m_pattern_ir", bist_pattern, m_lfsr);
  endtask

  task automatic m_scan_dr(input int len, input logic [63:0] din);
    logic [127:0] full, mk, cval;
    logic [63:0]  dout;
    int           l;
    logic         en;
    m_bist_tick();
    unique case (m_ir)
      4'd0, 4'd2: begin l = 39; cval = 128'(bsr_cap); end
      4'd1:       begin l = 32; cval = 128'(IDC); end
      4'd3:       begin l = 16; cval = 128'(m_misr); end
      default:    begin l = 1;  cval = '0; end
    endcase
    full = (128'(din) << l) | cval;
    mk   = (128'd1 << len) - 1;
    if (m_ir == 4'd0 || m_ir == 4'd2)
      m_upd = 39'(full >> len);
    scan_dr(len, din, dout, en);
    check("m_dr_out", 128'(dout), full & mk);
    check("m_dr_en", en, 1'b1);
    check("m_bsr_upd", bsr_upd, m_upd);
    check("m_pattern_dr", bist_pattern, m_lfsr);
  endtask

  task automatic m_idle(input int n);
    logic o, e, b;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, o, e, b);
      check("m_busy", b, m_ir == 4'd3);
      m_bist_tick();
      check("m_pattern_idle", bist_pattern, m_lfsr);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]   so;
    logic [63:0]  dout, r;
    logic [127:0] mk;
    logic [3:0]   op;
    logic         en, o, e, b;

    vecs[0] = '{4'h1, 32, 64'h0, 39'h0,
                64'h1876_5001, 39'h0, 1'b0, 1'b0};
    vecs[1] = '{4'hF, 4, 64'hD, 39'h0,
                64'hA, 39'h0, 1'b0, 1'b0};
    vecs[2] = '{4'h9, 4, 64'hD, 39'h0,
                64'hA, 39'h0, 1'b0, 1'b0};
    vecs[3] = '{4'h2, 39, 64'h7F_0000_0001, 39'h55_AAAA_5555,
                64'h55_AAAA_5555, 39'h7F_0000_0001, 1'b0, 1'b1};
    vecs[4] = '{4'h0, 39, 64'h00_1234_5678, 39'h7F_FFFF_FFFF,
                64'h7F_FFFF_FFFF, 39'h00_1234_5678, 1'b1, 1'b1};
    vecs[5] = '{4'h1, 40, 64'h1, 39'h0,
                64'h1_1876_5001, 39'h0, 1'b0, 1'b0};
    vecs[6] = '{4'hE, 1, 64'h1, 39'h0,
                64'h0, 39'h0, 1'b0, 1'b0};

    bsr_cap = '0;
    hw_reset();
    check("rst_tdo", tdo, 1'b0);
    check("rst_tdo_en", tdo_en, 1'b0);
    check("rst_ir", ir_q, 4'd1);
    check("rst_upd", bsr_upd, 39'h0);
    check("rst_pattern", bist_pattern, 16'd1);
    check("rst_extest", extest_mode, 1'b0);
    check("rst_busy", bist_busy, 1'b0);
    go(0);

    scan_dr(32, 64'h0, dout, en);
    check("first_idcode", dout, 64'h1876_5001);

    for (int v = 0; v < 7; v++) begin
      bsr_cap = vecs[v].cap;
      scan_ir(vecs[v].op, so, en);
      check("vec_ir_cap", so, 4'b0001);
      check("vec_ir_q", ir_q, vecs[v].op);
      mk = (128'd1 << vecs[v].len) - 1;
      scan_dr(vecs[v].len, vecs[v].din, dout, en);
      check("vec_dr_out", 128'(dout) & mk,
            128'(vecs[v].dout) & mk);
      check("vec_dr_en", en, 1'b1);
      if (vecs[v].chk_upd)
        check("vec_bsr_upd", bsr_upd, vecs[v].upd);
      check("vec_extest", extest_mode, vecs[v].ext);
    end

    // IDCODE scan split by a Pause-DR detour
    scan_ir(4'h1, so, en);
    dout = '0;
    go(1); go(0); go(0);
    for (int i = 0; i < 10; i++) begin
      tick(i == 9, 1'b0, o, e, b);
      dout[i] = o;
    end
    go(0);
    tick(1'b0, 1'b0, o, e, b);
    check("pause_en", e, 1'b0);
    go(0); go(0);
    go(1); go(0);
    for (int i = 10; i < 32; i++) begin
      tick(i == 31, 1'b0, o, e, b);
      dout[i] = o;
    end
    go(1); go(0);
    check("pause_idcode", dout, 64'h1876_5001);

    // five tms=1 from Shift-DR
    scan_ir(4'hF, so, en);
    go(1); go(0); go(0);
    check("shdr_en", tdo_en, 1'b1);
    for (int i = 0; i < 5; i++) go(1);
    check("tlr_from_shdr_ir", ir_q, 4'd1);
    check("tlr_from_shdr_en", tdo_en, 1'b0);
    go(0);

    // five tms=1 from Pause-IR with ones in the IR shifter
    scan_ir(4'h2, so, en);
    go(1); go(1); go(0); go(0);
    for (int i = 0; i < 4; i++) tick(i == 3, 1'b1, o, e, b);
    go(0);
    for (int i = 0; i < 5; i++) go(1);
    check("tlr_from_pause_ir", ir_q, 4'd1);
    go(0);

    // five tms=1 from Update-DR
    scan_ir(4'hF, so, en);
    go(1); go(0); go(1); go(1);
    for (int i = 0; i < 5; i++) go(1);
    check("tlr_from_upd_dr", ir_q, 4'd1);
    go(0);

    // BIST run with golden model
    hw_reset();
    go(0);
    m_init();
    bsr_cap = '0;
    m_scan_ir(4'd3);
    m_idle(100);
    m_scan_dr(16, 64'h0);
    m_bist_tick();
    go(1);
    check("bist_leave", bist_pattern, m_lfsr);
    go(1); go(0); go(1); go(0); go(0); go(0);
    check("bist_frozen", bist_pattern, m_lfsr);
    check("bist_busy_off", bist_busy, 1'b0);
    go(1); go(1); go(0);
    m_ir = 4'd1;
    m_lfsr = 16'd1;
    m_misr = 16'd0;
    check("bist_reseed", bist_pattern, 16'd1);
    check("bist_ir_back", ir_q, 4'd1);

    // random op mix against the model
    for (int it = 0; it < 300; it++) begin
      r = {$urandom(), $urandom()};
      bsr_cap = r[38:0];
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          case ($urandom_range(0, 7))
            0: op = 4'd0;
            1: op = 4'd1;
            2: op = 4'd2;
            3, 4: op = 4'd3;
            5: op = 4'hF;
            default: op = 4'($urandom_range(0, 15));
          endcase
          m_scan_ir(op);
        end
        3, 4, 5, 6: begin
          r = {$urandom(), $urandom()};
          m_scan_dr($urandom_range(1, 64), r);
        end
        default: m_idle($urandom_range(0, 12));
      endcase
    end

    // reset in the middle of an EXTEST boundary shift
    bsr_cap = 39'h12_3456_789A;
    scan_ir(4'h0, so, en);
    scan_dr(39, 64'h2A_5A5A_C3C3, dout, en);
    check("pre_rst_upd", bsr_upd, 39'h2A_5A5A_C3C3);
    check("pre_rst_extest", extest_mode, 1'b1);
    go(1); go(0); go(0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, o, e, b);
    check("mid_shift_en", tdo_en, 1'b1);
    hw_reset();
    check("mid_rst_en", tdo_en, 1'b0);
    check("mid_rst_tdo", tdo, 1'b0);
    check("mid_rst_upd", bsr_upd, 39'h0);
    check("mid_rst_ir", ir_q, 4'd1);
    check("mid_rst_extest", extest_mode, 1'b0);
    check("mid_rst_pattern", bist_pattern, 16'd1);
    go(0);
    scan_dr(32, 64'h0, dout, en);
    check("post_rst_idcode", dout, 64'h1876_5001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
